axi4_qos_rr_arbiter: RTL

//   Parametrised N-master arbiter for a single slave port of the AXI4 interconnect.

---
 rtl/axi4_qos_rr_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/axi4_qos_rr_arbiter.sv
// N-master QoS arbiter for one AXI4 slave port: highest QoS wins, round-robin breaks ties, grant locked until done.
// Optional build macro AXI4_ARB_AGING_EN promotes masters that have waited AGE_LIMIT cycles above every QoS level.
module axi4_qos_rr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int IDX_W       = $clog2(NUM_MASTERS),
   parameter int AGE_W       = 6,
   parameter int AGE_LIMIT   = 32
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [NUM_MASTERS-1:0]   req,
   input  logic [4*NUM_MASTERS-1:0] qos,
   input  logic                     done,
   output logic [NUM_MASTERS-1:0]   grant,
   output logic                     grant_valid,
   output logic [IDX_W-1:0]         grant_idx
);

   localparam logic STATE_IDLE   = 1'b0;
   localparam logic STATE_LOCKED = 1'b1;

   localparam logic [IDX_W:0]   NUM_M    = (IDX_W+1)'(NUM_MASTERS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS-1);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || AGE_LIMIT < 1 || AGE_LIMIT >= (1 << AGE_W)) begin : g_bad_params
      $error("axi4_qos_rr_arbiter: parameter out of range");
   end

   logic             state;
   logic [IDX_W-1:0] rr_ptr;
   logic [4:0]       eff_qos [NUM_MASTERS];

`ifdef AXI4_ARB_AGING_EN
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

   logic [AGE_W-1:0] age [NUM_MASTERS];

   always_ff @(posedge aclk) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (areset || !req[i] || grant[i]) begin
            age[i] <= '0;
         end else if (age[i] != AGE_MAX) begin
            age[i] <= age[i] + 1'b1;
         end
      end
   end

   // An aged master sits one level above the highest architectural QoS value.
   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         eff_qos[i] = (age[i] == AGE_MAX) ? 5'd16 : {1'b0, qos[4*i +: 4]};
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         eff_qos[i] = {1'b0, qos[4*i +: 4]};
      end
   end
`endif

   logic [4:0]       max_qos;
   logic [IDX_W-1:0] winner;
   logic [IDX_W:0]   scan;
   logic             found;

   // Scan upward from rr_ptr, wrapping, and take the first requester at the top QoS level.
   always_comb begin
      max_qos = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (req[i] && (eff_qos[i] > max_qos)) begin
            max_qos = eff_qos[i];
         end
      end
      winner = '0;
      found  = 1'b0;
      scan   = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (scan >= NUM_M) begin
            scan = scan - NUM_M;
         end
         if (!found && req[scan[IDX_W-1:0]] && (eff_qos[scan[IDX_W-1:0]] == max_qos)) begin
            found  = 1'b1;
            winner = scan[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= STATE_IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         rr_ptr      <= '0;
      end else if (state == STATE_IDLE) begin
         if (|req) begin
            state       <= STATE_LOCKED;
            grant       <= NUM_MASTERS'(1) << winner;
            grant_valid <= 1'b1;
            grant_idx   <= winner;
            rr_ptr      <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
         end
      end else begin
         // A withdrawn owner releases the port even without a completion pulse.
         if (done || !req[grant_idx]) begin
            state       <= STATE_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
         end
      end
   end

endmodule
